// File: rtl/pipe_sequencer_if.sv
// Run-control bundle between the debug unit / pipeline hazard logic and the sequencer.
// Slave modport is the sequencer side; master is the requester and pipeline side.
interface pipe_sequencer_if #(
    parameter int len_data = 32
);
    logic                cmd_valid;
    logic [1:0]          cmd;
    logic                cmd_ready;
    logic                stall_flag;
    logic                branch_taken;
    logic                jump;
    logic                halt_detected;
    logic                pipe_enable;
    logic                pc_enable;
    logic                if_id_enable;
    logic                flush_if_id;
    logic                flush_id_ex;
    logic                halt_flag_d;
    logic [2:0]          state;
    logic                done;
    logic [len_data-1:0] cycle_count;

    modport slave (
        input  cmd_valid, cmd, stall_flag, branch_taken, jump, halt_detected,
        output cmd_ready, pipe_enable, pc_enable, if_id_enable, flush_if_id,
               flush_id_ex, halt_flag_d, state, done, cycle_count
    );

    modport master (
        output cmd_valid, cmd, stall_flag, branch_taken, jump, halt_detected,
        input  cmd_ready, pipe_enable, pc_enable, if_id_enable, flush_if_id,
               flush_id_ex, halt_flag_d, state, done, cycle_count
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Run-control sequencer: debug commands -> pipeline enables/flushes, halt drain, done pulse.
// Enables/flushes are combinational from state; commands take effect the cycle after acceptance.
module pipe_sequencer #(
    parameter int len_data    = 32,
    parameter int drain_depth = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pipe_sequencer_if.slave        bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;
    localparam logic [3:0] DRAIN_LOAD = 4'(drain_depth);

    state_e              state_q, state_d;
    logic [3:0]          drain_cnt_q, drain_cnt_d;
    logic [len_data-1:0] cycle_count_q, cycle_count_d;
    logic                done_q, done_d;

    logic run_like, draining, pipe_en, hlt_acc, front_adv, cmd_acc;

    always_comb begin
        run_like  = (state_q == ST_RUN) || (state_q == ST_STEP);
        draining  = (state_q == ST_DRAIN);
        pipe_en   = run_like || draining;
        // A halt seen alongside a taken branch is on the wrong path.
        hlt_acc   = run_like && bus.halt_detected && !bus.branch_taken;
        front_adv = run_like && (bus.branch_taken || (!bus.stall_flag && !bus.halt_detected));
        cmd_acc   = bus.cmd_valid && bus.cmd_ready;
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign bus.pipe_enable  = pipe_en;
    assign bus.pc_enable    = front_adv;
    assign bus.if_id_enable = front_adv;
    assign bus.flush_if_id  = run_like && (bus.branch_taken || bus.jump);
    assign bus.flush_id_ex  = pipe_en && (bus.branch_taken || draining);
    assign bus.halt_flag_d  = hlt_acc;
    assign bus.state        = state_q;
    assign bus.done         = done_q;
    assign bus.cycle_count  = cycle_count_q;

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        done_d        = 1'b0;

        if (pipe_en && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + len_data'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && (bus.cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && (bus.cmd == CMD_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (hlt_acc) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (cmd_acc && (bus.cmd == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (hlt_acc) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 4'd1;
                if (drain_cnt_q == 4'd1) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end
            end
            ST_HALTED: begin
                if (cmd_acc && (bus.cmd == CMD_CLEAR)) begin
                    state_d       = ST_IDLE;
                    cycle_count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= 4'd0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed run/step/halt scenarios then random traffic,
// all outputs compared every cycle against a timestamp-based reference model.
module tb_pipe_sequencer;
    localparam int LEN   = 6;
    localparam int DEPTH = 3;
    localparam int MAXC  = (1 << LEN) - 1;

    logic clk;
    logic reset;
    pipe_sequencer_if #(.len_data(LEN)) bus ();

    pipe_sequencer #(.len_data(LEN), .drain_depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int done_seen = 0;

    // Reference model: mode numbers follow the published state codes; drain
    // progress is tracked as the cycle index at which the halt was accepted.
    int m_mode  = 0;
    int m_cyc   = 0;
    int m_halt_at = 0;
    int m_count = 0;
    int m_done  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit cv, input bit [1:0] c,
                              input bit bt, input bit hd);
        bit active, halt_ok, acc;
        active  = (m_mode == 1) || (m_mode == 2);
        halt_ok = active && hd && !bt;
        acc     = cv && (m_mode == 0 || m_mode == 1 || m_mode == 4);
        m_cyc++;
        if (r) begin
            m_mode = 0; m_count = 0; m_done = 0;
            return;
        end
        if ((active || m_mode == 3) && m_count < MAXC) m_count++;
        m_done = 0;
        case (m_mode)
            0: if (acc && c == 2'b01) m_mode = 1;
               else if (acc && c == 2'b10) m_mode = 2;
            1: if (halt_ok) begin m_mode = 3; m_halt_at = m_cyc - 1; end
               else if (acc && c == 2'b11) m_mode = 0;
            2: if (halt_ok) begin m_mode = 3; m_halt_at = m_cyc - 1; end
               else m_mode = 0;
            3: if (m_cyc - 1 - m_halt_at == DEPTH) begin m_mode = 4; m_done = 1; end
            4: if (acc && c == 2'b00) begin m_mode = 0; m_count = 0; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic tick(input bit r, input bit cv, input bit [1:0] c, input bit st,
                        input bit bt, input bit jp, input bit hd);
        bit active, pe;
        reset             = r;
        bus.cmd_valid     = cv;
        bus.cmd           = c;
        bus.stall_flag    = st;
        bus.branch_taken  = bt;
        bus.jump          = jp;
        bus.halt_detected = hd;
        #4;
        active = (m_mode == 1) || (m_mode == 2);
        pe     = active || (m_mode == 3);
        check("state",        32'(bus.state),        32'(m_mode));
        check("pipe_enable",  32'(bus.pipe_enable),  32'(pe));
        check("pc_enable",    32'(bus.pc_enable),    32'(active && (bt || (!st && !hd))));
        check("if_id_enable", 32'(bus.if_id_enable), 32'(active && (bt || (!st && !hd))));
        check("flush_if_id",  32'(bus.flush_if_id),  32'(active && (bt || jp)));
        check("flush_id_ex",  32'(bus.flush_id_ex),  32'(pe && (bt || m_mode == 3)));
        check("halt_flag_d",  32'(bus.halt_flag_d),  32'(active && hd && !bt));
        check("cmd_ready",    32'(bus.cmd_ready),    32'(m_mode == 0 || m_mode == 1 || m_mode == 4));
        check("done",         32'(bus.done),         32'(m_done));
        check("cycle_count",  32'(bus.cycle_count),  32'(m_count));
        if (bus.done === 1'b1) done_seen++;
        @(posedge clk);
        model_step(r, cv, c, bt, hd);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        bus.cmd_valid = 0; bus.cmd = 0; bus.stall_flag = 0;
        bus.branch_taken = 0; bus.jump = 0; bus.halt_detected = 0;
        @(posedge clk);
        #1;

        // Reset state and idle.
        tick(1, 0, 2'b00, 0, 0, 0, 0);
        idle(5);

        // RUN at cycle 0, STOP at cycle 10.
        tick(0, 1, 2'b01, 0, 0, 0, 0);
        idle(9);
        tick(0, 1, 2'b11, 0, 0, 0, 0);
        check("run_stop_count", 32'(bus.cycle_count), 32'd10);
        check("run_stop_idle",  32'(bus.state),       32'd0);

        // Three single steps.
        tick(1, 0, 2'b00, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 2'b10, 0, 0, 0, 0);
            idle(2);
        end
        check("step_count", 32'(bus.cycle_count), 32'd3);

        // Hazard arbitration in RUN.
        tick(0, 1, 2'b01, 0, 0, 0, 0);
        tick(0, 0, 2'b00, 1, 0, 0, 0);
        tick(0, 0, 2'b00, 1, 1, 0, 0);
        tick(0, 0, 2'b00, 0, 0, 1, 0);
        // Halt with a taken branch is ignored.
        tick(0, 0, 2'b00, 0, 1, 0, 1);
        check("halt_wrong_path", 32'(bus.state), 32'd1);

        // Halt at cycle 20, STOP offered during drain, then CLEAR.
        tick(1, 0, 2'b00, 0, 0, 0, 0);
        tick(0, 1, 2'b01, 0, 0, 0, 0);
        idle(19);
        d0 = done_seen;
        tick(0, 0, 2'b00, 0, 0, 0, 1);
        for (int k = 0; k < DEPTH; k++) tick(0, 1, 2'b11, 0, 0, 0, 0);
        check("halted_state", 32'(bus.state), 32'd4);
        tick(0, 0, 2'b00, 0, 0, 0, 0);
        idle(2);
        check("done_once", 32'(done_seen - d0), 32'd1);
        tick(0, 1, 2'b00, 0, 0, 0, 0);
        check("clear_count", 32'(bus.cycle_count), 32'd0);

        // Reset on the second drain cycle: no done pulse.
        tick(0, 1, 2'b01, 0, 0, 0, 0);
        idle(3);
        tick(0, 0, 2'b00, 0, 0, 0, 1);
        tick(0, 0, 2'b00, 0, 0, 0, 0);
        d0 = done_seen;
        tick(1, 0, 2'b00, 0, 0, 0, 0);
        idle(6);
        check("no_done_after_reset", 32'(done_seen - d0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            bit r, cv, st, bt, jp, hd;
            bit [1:0] c;
            r  = ($urandom_range(0, 149) == 0);
            cv = ($urandom_range(0, 3) == 0);
            c  = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 5) == 0);
            jp = ($urandom_range(0, 5) == 0);
            hd = ($urandom_range(0, 11) == 0);
            tick(r, cv, c, st, bt, jp, hd);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Run-control sequencer for the 5-stage MIPS pipeline. It turns debug-unit commands (run, step, stop, clear) into per-cycle enables and flushes for PC, IF/ID and ID/EX, arbitrating them against the load-use stall from the ID stage, taken branches from EX and a decoded halt. On halt, it injects the halt marker into ID/EX, lets the instructions ahead drain through EX/MEM/WB, and reports completion.

## Interface
Parameters:
- len_data, 32, width of cycle_count
- drain_depth, 3, pipeline cycles after halt acceptance before halted (EX, MEM, WB); legal 1..15

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- cmd_valid  in  1  debug command strobe
- cmd  in  2  01 RUN, 10 STEP, 11 STOP, 00 CLEAR
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- stall_flag  in  1  load-use stall from ID stage
- branch_taken  in  1  taken branch resolved in EX
- jump  in  1  flag_jump | flag_jump_register from ID
- halt_detected  in  1  halt opcode currently in ID
- pipe_enable  out  1  clock enable for IF/ID, ID/EX, EX/MEM, MEM/WB latches and register-file write
- pc_enable  out  1  PC update enable
- if_id_enable  out  1  IF/ID load enable
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  clear ID/EX (drives ID/EX flush)
- halt_flag_d  out  1  halt marker into ID/EX
- state  out  3  0 IDLE, 1 RUN, 2 STEP, 3 DRAIN, 4 HALTED
- done  out  1  one-cycle pulse on the first HALTED cycle
- cycle_count  out  len_data  count of cycles with pipe_enable=1, saturating

## Operation
- Registered: state, drain_cnt (4 bit), cycle_count, done. All other outputs are combinational from state and inputs.
- pipe_enable = state is RUN, STEP or DRAIN.
- hlt_acc = pipe_enable & halt_detected & ~branch_taken & state is RUN or STEP. A halt on a wrong path (branch_taken in the same cycle) is ignored.
- pc_enable = if_id_enable = pipe_enable & state≠DRAIN & (branch_taken | (~stall_flag & ~halt_detected)). branch_taken overrides stall.
- flush_if_id = pipe_enable & state≠DRAIN & (branch_taken | jump).
- flush_id_ex = pipe_enable & (branch_taken | state==DRAIN).
- halt_flag_d = hlt_acc.
- cmd_ready = state is IDLE, RUN or HALTED.
- Transitions:
  - IDLE: RUN→RUN; STEP→STEP; other commands accepted and ignored.
  - RUN: hlt_acc→DRAIN, with priority over a simultaneous STOP. STOP→IDLE; the acceptance cycle still advances.
  - STEP: lasts exactly 1 cycle. hlt_acc→DRAIN, else →IDLE.
  - DRAIN: drain_cnt is loaded with drain_depth on entry and decremented every cycle. When drain_cnt==1, go to HALTED. DRAIN therefore lasts exactly drain_depth cycles.
  - HALTED: everything frozen. CLEAR→IDLE and zeroes cycle_count. Other commands are ignored.
- cycle_count increments on each cycle with pipe_enable=1 and holds at all-ones.
- done=1 only on the cycle after the DRAIN→HALTED transition edge, i.e. the first HALTED cycle.

## Timing
- Reset values: state=IDLE, drain_cnt=0, cycle_count=0, done=0. Hence pipe_enable, pc_enable, if_id_enable, flush_if_id, flush_id_ex and halt_flag_d are 0, and cmd_ready=1.
- Command latency: a command accepted at edge n takes effect in the state seen from cycle n+1.
- Halt at cycle t in RUN (no branch):
  - Cycle t: halt_flag_d=1, pc_enable=0.
  - Cycles t+1..t+drain_depth: DRAIN.
  - Cycle t+drain_depth+1: HALTED and done=1.
- Reset asserted in any state, including mid-DRAIN: IDLE on the next edge, counters cleared.
- A cmd_valid while cmd_ready=0 is dropped. The requester must hold cmd_valid until it sees ready.

## Test plan
- Reset, then 5 idle cycles → state=0, all enables/flushes 0, cmd_ready=1, cycle_count=0.
- RUN at cycle 0, STOP accepted at cycle 10, no hazards → pipe_enable and pc_enable high for cycles 1..10, IDLE from cycle 11, cycle_count=10.
- Three STEP commands separated by idle cycles → exactly three single-cycle pipe_enable pulses, state returns to 0 after each, cycle_count=3.
- In RUN: stall_flag=1 alone → pc_enable=0, pipe_enable=1. stall_flag=1 with branch_taken=1 → pc_enable=1, flush_if_id=1, flush_id_ex=1. jump=1 alone → flush_if_id=1, flush_id_ex=0.
- In RUN, halt_detected at cycle 20 (drain_depth=3):
  - halt_flag_d=1 at cycle 20.
  - DRAIN cycles 21..23 with flush_id_ex=1 and cmd_ready=0; STOP offered there is not accepted.
  - HALTED at cycle 24 with done=1 only at 24.
  - CLEAR → IDLE with cycle_count=0.
- halt_detected together with branch_taken → stays RUN, halt_flag_d=0. Reset asserted at the second DRAIN cycle → IDLE next cycle, done never pulses.
